// File: rtl/rst_seq_pkg.sv
// Shared state encoding and width helpers for the staged reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } seq_state_e;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Sequencer-facing bundle: restart request, per-stage done/reset, status.
interface rst_seq_if #(
    parameter int N_STAGES = 4
);
    import rst_seq_pkg::*;

    localparam int IDX_W = clog2_min1(N_STAGES);

    logic                soft_rst_req;
    logic [N_STAGES-1:0] stage_done;
    logic [N_STAGES-1:0] stage_rst;
    logic                sys_ready;
    logic                busy;
    logic                fault;
    logic [IDX_W-1:0]    fault_stage;

    modport master (
        input  soft_rst_req,
        input  stage_done,
        output stage_rst,
        output sys_ready,
        output busy,
        output fault,
        output fault_stage
    );

    modport slave (
        output soft_rst_req,
        output stage_done,
        input  stage_rst,
        input  sys_ready,
        input  busy,
        input  fault,
        input  fault_stage
    );

endinterface

// File: rtl/rst_seq_timer.sv
// Clear/enable up-counter with a terminal-count compare, shared by hold and ack waits.
module rst_seq_timer #(
    parameter int W = 4
) (
    input  logic         clk_50m,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/rst_sequencer.sv
// Staged per-subsystem reset release with soft restart.
// RST_SEQ_TIMEOUT_EN adds a stage_done timeout that parks the sequencer in FAULT.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int N_STAGES    = 4,
    parameter int HOLD_CYC    = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic      clk_50m,
    input  logic      rst,
    rst_seq_if.master seq
);

    localparam int IDX_W = clog2_min1(N_STAGES);
    localparam int CNT_W = clog2_min1(max_int(HOLD_CYC, ACK_TIMEOUT));

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);
    localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYC - 1);

    seq_state_e          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                req_q, req_d;
    logic                req_prev_q, req_prev_d;
    logic [N_STAGES-1:0] stage_rst_q, stage_rst_d;
    logic                sys_ready_q, sys_ready_d;
    logic                busy_q, busy_d;
    logic                fault_q, fault_d;
    logic [IDX_W-1:0]    fault_stage_q, fault_stage_d;

    logic             tc;
    logic             tmr_clr;
    logic             tmr_en;
    logic [CNT_W-1:0] tc_val;
    logic             in_hold;
    logic             in_wait;
    logic             hold_done;
    logic             ack;
    logic             tmo;
    logic             soft_edge;
    logic             restart;

    assign in_hold   = (state_q == ST_HOLD);
    assign in_wait   = (state_q == ST_WAIT);
    assign hold_done = in_hold && tc;
    assign ack       = in_wait && seq.stage_done[idx_q];
    assign soft_edge = req_q && !req_prev_q;
    assign restart   = soft_edge &&
                       ((state_q == ST_RUN) || (state_q == ST_FAULT));

`ifdef RST_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] ACK_TC = CNT_W'(ACK_TIMEOUT - 1);

    // A done arriving on the terminal cycle still advances normally.
    assign tmo    = in_wait && !seq.stage_done[idx_q] && tc;
    assign tmr_en = in_hold || in_wait;
    assign tc_val = in_wait ? ACK_TC : HOLD_TC;
`else
    assign tmo    = 1'b0;
    assign tmr_en = in_hold;
    assign tc_val = HOLD_TC;
`endif

    assign tmr_clr = hold_done || ack || tmo || restart;

    rst_seq_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk_50m (clk_50m),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .tc_val  (tc_val),
        .tc      (tc)
    );

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q       <= ST_HOLD;
            idx_q         <= '0;
            req_q         <= 1'b0;
            req_prev_q    <= 1'b0;
            stage_rst_q   <= '1;
            sys_ready_q   <= 1'b0;
            busy_q        <= 1'b1;
            fault_q       <= 1'b0;
            fault_stage_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            req_q         <= req_d;
            req_prev_q    <= req_prev_d;
            stage_rst_q   <= stage_rst_d;
            sys_ready_q   <= sys_ready_d;
            busy_q        <= busy_d;
            fault_q       <= fault_d;
            fault_stage_q <= fault_stage_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        req_d      = seq.soft_rst_req;
        req_prev_d = req_q;
        unique case (state_q)
            ST_HOLD: begin
                if (tc) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ack) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_RUN;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_HOLD;
                    end
                end else if (tmo) begin
                    state_d = ST_FAULT;
                end
            end
            ST_RUN, ST_FAULT: begin
                if (soft_edge) begin
                    state_d = ST_HOLD;
                    idx_d   = '0;
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    // Outputs follow the next state so every port comes straight from a flop.
    always_comb begin
        stage_rst_d   = stage_rst_q;
        fault_stage_d = fault_stage_q;
        if (hold_done) stage_rst_d[idx_q] = 1'b0;
        if (tmo || restart) stage_rst_d = '1;
        if (tmo) fault_stage_d = idx_q;
        sys_ready_d = (state_d == ST_RUN);
        busy_d      = (state_d == ST_HOLD) || (state_d == ST_WAIT);
        fault_d     = (state_d == ST_FAULT);
    end

    assign seq.stage_rst   = stage_rst_q;
    assign seq.sys_ready   = sys_ready_q;
    assign seq.busy        = busy_q;
    assign seq.fault       = fault_q;
    assign seq.fault_stage = fault_stage_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: directed latency cases plus random traffic.
// Timeline reference model tracks hold start / release timestamps per stage.
module tb_rst_sequencer;

    localparam int N    = 4;
    localparam int HOLD = 16;
    localparam int ACK  = 32;
`ifdef RST_SEQ_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif
    localparam int FULL = N * (HOLD + 1);

    logic clk_50m = 1'b0;
    logic rst     = 1'b1;

    rst_seq_if #(.N_STAGES(N)) bus ();

    rst_sequencer #(
        .N_STAGES    (N),
        .HOLD_CYC    (HOLD),
        .ACK_TIMEOUT (ACK)
    ) dut (
        .clk_50m (clk_50m),
        .rst     (rst),
        .seq     (bus)
    );

    always #10 clk_50m = ~clk_50m;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int t0       = 0;
    int rel_at [N];

    // Reference: timestamps of the current stage's hold start and release.
    logic [N-1:0] m_rst      = '1;
    bit           m_ready    = 1'b0;
    bit           m_fault    = 1'b0;
    bit           m_released = 1'b0;
    int           m_idx      = 0;
    int           m_hold     = 0;
    int           m_rel      = 0;
    int           m_fstage   = 0;
    bit           h1         = 1'b0;
    bit           h2         = 1'b0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic restart_model(input int c);
        m_rst      = '1;
        m_ready    = 1'b0;
        m_fault    = 1'b0;
        m_idx      = 0;
        m_released = 1'b0;
        m_hold     = c + 1;
    endtask

    task automatic model_edge();
        int c;
        bit sedge;
        c = cyc;
        if (rst) begin
            restart_model(c);
            m_fstage = 0;
            h1 = 1'b0;
            h2 = 1'b0;
        end else begin
            sedge = h1 && !h2;
            if ((m_ready || m_fault) && sedge) begin
                restart_model(c);
            end else if (!m_ready && !m_fault) begin
                if (!m_released) begin
                    if (c + 1 == m_hold + HOLD) begin
                        m_rst[m_idx] = 1'b0;
                        m_released   = 1'b1;
                        m_rel        = c + 1;
                    end
                end else if (bus.stage_done[m_idx]) begin
                    if (m_idx == N - 1) begin
                        m_ready = 1'b1;
                    end else begin
                        m_idx++;
                        m_released = 1'b0;
                        m_hold     = c + 1;
                    end
                end else if (TMO && (c - m_rel == ACK - 1)) begin
                    m_fault  = 1'b1;
                    m_fstage = m_idx;
                    m_rst    = '1;
                end
            end
            h2 = h1;
            h1 = bus.soft_rst_req;
        end
    endtask

    task automatic step();
        @(posedge clk_50m);
        model_edge();
        cyc++;
        #1;
        chk("stage_rst", 32'(bus.stage_rst), 32'(m_rst));
        chk("sys_ready", 32'(bus.sys_ready), 32'(m_ready));
        chk("busy", 32'(bus.busy), 32'(!m_ready && !m_fault));
        chk("fault", 32'(bus.fault), 32'(m_fault));
        chk("fault_stage", 32'(bus.fault_stage), 32'(m_fstage));
        for (int k = 0; k < N; k++) begin
            if (bus.stage_rst[k] === 1'b0 && rel_at[k] < 0) rel_at[k] = cyc;
        end
    endtask

    task automatic clear_marks();
        for (int k = 0; k < N; k++) rel_at[k] = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        t0 = cyc;
        clear_marks();
    endtask

    task automatic run_until_ready(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.sys_ready === 1'b1) begin
                at = cyc;
                break;
            end
        end
        chk("ready_seen", 32'(bus.sys_ready), 32'd1);
    endtask

    task automatic run_until_rst(input logic [N-1:0] pat, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.stage_rst === pat) break;
        end
        chk("rst_pat_seen", 32'(bus.stage_rst), 32'(pat));
    endtask

    task automatic pulse_soft();
        bus.soft_rst_req = 1'b1;
        step();
        bus.soft_rst_req = 1'b0;
        step();
    endtask

    initial begin
        int at;
        int td;
        int r;
        int fc;
        bit s;
        bus.soft_rst_req = 1'b0;
        bus.stage_done   = '1;
        clear_marks();

        // reset state and nominal release schedule
        do_reset();
        chk("rst_busy", 32'(bus.busy), 32'd1);
        chk("rst_stage", 32'(bus.stage_rst), 32'hF);
        run_until_ready(200, at);
        chk("t1_ready_cyc", 32'(at - t0), 32'(FULL));
        for (int k = 0; k < N; k++) begin
            chk("t1_rel", 32'(rel_at[k] - t0), 32'(k * (HOLD + 1) + HOLD));
        end

        // stage 2 slow to finish
        bus.stage_done = 4'b1011;
        do_reset();
        run_until_rst(4'b1000, 200);
        repeat (TMO ? ACK - 12 : 200) step();
        chk("t2_hold", 32'(bus.stage_rst), 32'h8);
        chk("t2_busy", 32'(bus.busy), 32'd1);
        bus.stage_done = '1;
        td = cyc;
        run_until_ready(100, at);
        chk("t2_lat", 32'(at - td), 32'(HOLD + 2));

        // soft restart pulse from RUN, then held-high level
        pulse_soft();
        chk("t3_rst_all", 32'(bus.stage_rst), 32'hF);
        chk("t3_ready_lo", 32'(bus.sys_ready), 32'd0);
        t0 = cyc;
        clear_marks();
        run_until_ready(200, at);
        chk("t3_replay", 32'(at - t0), 32'(FULL));
        bus.soft_rst_req = 1'b1;
        step();
        step();
        chk("t3_lvl_rst", 32'(bus.stage_rst), 32'hF);
        t0 = cyc;
        run_until_ready(200, at);
        chk("t3_lvl_replay", 32'(at - t0), 32'(FULL));
        repeat (40) step();
        chk("t3_no_retrig", 32'(bus.sys_ready), 32'd1);
        bus.soft_rst_req = 1'b0;
        step();

        // rst while waiting on stage 1
        bus.stage_done = 4'b1101;
        do_reset();
        run_until_rst(4'b1100, 100);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_rst", 32'(bus.stage_rst), 32'hF);
        t0 = cyc;
        bus.stage_done = '1;
        run_until_ready(200, at);
        chk("t4_reseq", 32'(at - t0), 32'(FULL));

`ifdef RST_SEQ_TIMEOUT_EN
        // stage 1 never acknowledges
        bus.stage_done = 4'b1101;
        do_reset();
        run_until_rst(4'b1100, 100);
        r  = cyc;
        fc = -1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.fault === 1'b1) begin
                fc = cyc;
                break;
            end
        end
        chk("t5_fault", 32'(bus.fault), 32'd1);
        chk("t5_lat", 32'(fc - r), 32'(ACK));
        chk("t5_fstage", 32'(bus.fault_stage), 32'd1);
        chk("t5_rst_all", 32'(bus.stage_rst), 32'hF);
        bus.stage_done = '1;
        pulse_soft();
        chk("t5_fault_clr", 32'(bus.fault), 32'd0);
        run_until_ready(200, at);
`endif

        // soft edge during HOLD is discarded
        bus.stage_done = '1;
        do_reset();
        repeat (5) step();
        pulse_soft();
        run_until_ready(200, at);
        chk("t6_ready_cyc", 32'(at - t0), 32'(FULL));
        chk("t6_rel3", 32'(rel_at[N-1] - t0), 32'((N - 1) * (HOLD + 1) + HOLD));

        // random traffic against the timeline model
        s = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) bus.stage_done = N'($urandom);
            if ($urandom_range(0, 30) == 0) s = ~s;
            bus.soft_rst_req = s;
            rst = ($urandom_range(0, 400) == 0);
            step();
        end
        rst = 1'b0;
        bus.soft_rst_req = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
